// File: rtl/dmem_pipe.sv
// dmem_pipe: byte-strobed data RAM slave with registered, backpressured reads and write acks.
module dmem_pipe #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH = 4096,
   parameter int DEC_W = 16,
   parameter logic [DEC_W-1:0] BASE = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mst_wr_valid,
   input  logic [ADDR_W-1:0]   mst_wr_addr,
   input  logic [DATA_W-1:0]   mst_wr_data,
   input  logic [DATA_W/8-1:0] mst_wr_strb,
   output logic                slv_wr_ready,
   output logic                slv_wr_ack,
   output logic                slv_wr_err,
   input  logic                mst_rd_valid,
   input  logic [ADDR_W-1:0]   mst_rd_addr,
   output logic                slv_rd_ready,
   output logic                slv_rd_valid,
   output logic [DATA_W-1:0]   slv_rd_data,
   output logic                slv_rd_err,
   input  logic                mst_rd_ready
);
   localparam int NB = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t state_q, state_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q, fwd_q, fwd_d, merged;
   logic [NB-1:0] mask_q, mask_d;
   logic rd_err_q, rd_err_d, wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
   logic wr_in, rd_in, wr_en, rd_acc, unused_addr;
   logic [IDX_W-1:0] wr_idx, rd_idx;

   assign wr_in = mst_wr_addr[ADDR_W-1 -: DEC_W] == BASE;
   assign rd_in = mst_rd_addr[ADDR_W-1 -: DEC_W] == BASE;
   assign wr_idx = mst_wr_addr[OFF_W +: IDX_W];
   assign rd_idx = mst_rd_addr[OFF_W +: IDX_W];
   assign unused_addr = ^{mst_wr_addr, mst_rd_addr};
   assign slv_wr_ready = !rst;
   assign slv_rd_valid = state_q == FULL;
   assign slv_rd_ready = !rst && (!slv_rd_valid || mst_rd_ready);
   assign wr_en = mst_wr_valid && slv_wr_ready && wr_in;
   assign rd_acc = mst_rd_valid && slv_rd_ready;
   assign slv_wr_ack = wr_ack_q;
   assign slv_wr_err = wr_err_q;
   assign slv_rd_err = rd_err_q;
   assign slv_rd_data = slv_rd_valid && !rd_err_q ? merged : '0;

   always_comb begin
      state_d = rd_acc ? FULL : (mst_rd_ready ? EMPTY : state_q);
      rd_err_d = rd_acc ? !rd_in : rd_err_q;
      fwd_d = rd_acc ? mst_wr_data : fwd_q;
      // RAM reads old data on a same-word collision; remember which lanes to overlay
      mask_d = rd_acc ? ((wr_en && rd_in && rd_idx == wr_idx) ? mst_wr_strb : '0) : mask_q;
      wr_ack_d = mst_wr_valid;
      wr_err_d = mst_wr_valid && !wr_in;
      merged = ram_q;
      for (int i = 0; i < NB; i++)
         if (mask_q[i]) merged[i*8 +: 8] = fwd_q[i*8 +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         rd_err_q <= 1'b0;
         mask_q <= '0;
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_err_q <= rd_err_d;
         mask_q <= mask_d;
         wr_ack_q <= wr_ack_d;
         wr_err_q <= wr_err_d;
         fwd_q <= fwd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_acc) ram_q <= mem[rd_idx];
      for (int i = 0; i < NB; i++)
         if (wr_en && mst_wr_strb[i]) mem[wr_idx][i*8 +: 8] <= mst_wr_data[i*8 +: 8];
   end
endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: directed plan scenarios plus random traffic against a word-array model.
module tb_dmem_pipe;
   logic clk = 0;
   logic rst, mst_wr_valid, mst_rd_valid, mst_rd_ready;
   logic [31:0] mst_wr_addr, mst_wr_data, mst_rd_addr, slv_rd_data;
   logic [3:0] mst_wr_strb;
   logic slv_wr_ready, slv_wr_ack, slv_wr_err, slv_rd_ready, slv_rd_valid, slv_rd_err;

   int n_vec = 0, n_bad = 0;
   logic e_ack = 0, e_werr = 0, e_val = 0, e_rerr = 0, chk_d = 0;
   logic [31:0] e_data = 0;
   logic [31:0] m [64];

   always #5 clk = ~clk;

   dmem_pipe #(.DEPTH(64)) dut (
      .clk(clk), .rst(rst),
      .mst_wr_valid(mst_wr_valid), .mst_wr_addr(mst_wr_addr), .mst_wr_data(mst_wr_data),
      .mst_wr_strb(mst_wr_strb), .slv_wr_ready(slv_wr_ready), .slv_wr_ack(slv_wr_ack),
      .slv_wr_err(slv_wr_err), .mst_rd_valid(mst_rd_valid), .mst_rd_addr(mst_rd_addr),
      .slv_rd_ready(slv_rd_ready), .slv_rd_valid(slv_rd_valid), .slv_rd_data(slv_rd_data),
      .slv_rd_err(slv_rd_err), .mst_rd_ready(mst_rd_ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic inr(input logic [31:0] a);
      return a[31:16] == 16'h0000;
   endfunction

   task automatic cyc(input logic r, input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input logic rv, input logic [31:0] ra, input logic rr);
      logic acc;
      rst = r; mst_wr_valid = wv; mst_wr_addr = wa; mst_wr_data = wd; mst_wr_strb = ws;
      mst_rd_valid = rv; mst_rd_addr = ra; mst_rd_ready = rr;
      #1;
      chk("wr_ready", 32'(slv_wr_ready), 32'(!r));
      chk("rd_ready", 32'(slv_rd_ready), 32'(!r && (!e_val || rr)));
      acc = !r && rv && (!e_val || rr);
      @(posedge clk);
      if (r) begin
         e_ack = 0; e_werr = 0; e_val = 0; e_rerr = 0; e_data = 0; chk_d = 1;
      end else begin
         e_ack = wv;
         e_werr = wv && !inr(wa);
         if (wv && inr(wa))
            for (int i = 0; i < 4; i++)
               if (ws[i]) m[(wa >> 2) % 64][i*8 +: 8] = wd[i*8 +: 8];
         if (acc) begin
            e_val = 1;
            e_rerr = !inr(ra);
            e_data = inr(ra) ? m[(ra >> 2) % 64] : 32'h0;
         end else if (rr) e_val = 0;
         chk_d = e_val;
      end
      @(negedge clk);
      chk("wr_ack", 32'(slv_wr_ack), 32'(e_ack));
      chk("wr_err", 32'(slv_wr_err), 32'(e_werr));
      chk("rd_valid", 32'(slv_rd_valid), 32'(e_val));
      if (e_val || r) chk("rd_err", 32'(slv_rd_err), 32'(e_rerr));
      if (chk_d) chk("rd_data", slv_rd_data, e_data);
   endtask

   task automatic idle(input logic rr);
      cyc(0, 0, 0, 0, 0, 0, 0, rr);
   endtask

   initial begin
      logic [31:0] wa, ra;
      cyc(1, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      for (int w = 0; w < 64; w++) cyc(0, 1, w * 4, $urandom, 4'hF, 0, 0, 1);
      cyc(0, 1, 32'h20, 32'h0, 4'hF, 0, 0, 1);
      // strobed writes then read back
      cyc(0, 1, 32'h10, 32'hAABBCCDD, 4'b1111, 0, 0, 1);
      cyc(0, 1, 32'h10, 32'h11223344, 4'b0101, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1, 32'h10, 1);
      chk("plan_strb", slv_rd_data, 32'hAA22CC44);
      idle(1);
      // out of range
      cyc(0, 1, 32'h0001_0000, 32'hDEADBEEF, 4'hF, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1, 32'h0001_0000, 1);
      cyc(0, 0, 0, 0, 0, 1, 32'h0, 1);
      // backpressure
      cyc(0, 0, 0, 0, 0, 1, 32'h4, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'h4, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'h4, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'h4, 1);
      cyc(0, 0, 0, 0, 0, 1, 32'h8, 1);
      idle(1);
      idle(1);
      // same-cycle collision
      cyc(0, 1, 32'h20, 32'hFFFF0000, 4'b1100, 1, 32'h20, 1);
      chk("plan_coll", slv_rd_data, 32'hFFFF0000);
      // reset while response pending
      cyc(0, 0, 0, 0, 0, 1, 32'h10, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      idle(0);
      idle(1);
      for (int n = 0; n < 3000; n++) begin
         wa = $urandom_range(0, 1023);
         ra = $urandom_range(3, 0) == 0 ? wa : 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 7) == 0) wa[31:16] = 16'($urandom_range(1, 65535));
         if ($urandom_range(0, 7) == 0) ra[31:16] = 16'($urandom_range(1, 65535));
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, wa, $urandom, 4'($urandom),
             $urandom_range(0, 2) != 0, ra, $urandom_range(0, 9) < 7);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
